// File: rtl/rr_grant_arbiter.sv
// Eight-way grant arbiter for one shared resource. Supports fixed-priority and
// round-robin selection, holds each grant until the owner releases it or drops
// its request, and can force a release after a programmable hold time.
module rr_grant_arbiter #(
   parameter int unsigned MAX_HOLD = 16, // 0 disables the hold timeout
   parameter int unsigned HOLD_W   = 5   // 2**HOLD_W must exceed MAX_HOLD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rr_mode,
   input  logic [7:0] req,
   input  logic       release_i,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   // Last hold count of a grant; only meaningful when the timeout is enabled.
   localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

   state_e            state_q, state_d;
   logic [7:0]        gnt_q, gnt_d;
   logic [2:0]        gnt_idx_q, gnt_idx_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic              timeout_q, timeout_d;
   logic [2:0]        rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [7:0] cand_mask;
   logic [2:0] cand;
   logic       pick_found;
   logic [2:0] pick_idx;
   logic       end_release;
   logic       end_drop;
   logic       end_hold;
   logic       end_grant;

   // Candidate selection; the current owner is excluded while busy so a
   // released or timed-out owner cannot immediately re-win against others.
   always_comb begin
      cand_mask  = (state_q == StBusy) ? (req & ~gnt_q) : req;
      cand       = 3'd0;
      pick_found = 1'b0;
      pick_idx   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         cand = rr_mode ? (rr_ptr_q + 3'(k)) : 3'(k);
         if (!pick_found && cand_mask[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // End-of-grant conditions for the current owner.
   always_comb begin
      end_release = release_i;
      end_drop    = ~req[gnt_idx_q];
      end_hold    = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast);
      end_grant   = end_release | end_drop | end_hold;
   end

   // Next-state logic for the FSM, grant registers, pointer and hold counter.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      rr_ptr_d    = rr_ptr_q;
      hold_cnt_d  = hold_cnt_q;

      case (state_q)
         StIdle: begin
            if (en && pick_found) begin
               state_d     = StBusy;
               gnt_d       = 8'd1 << pick_idx;
               gnt_idx_d   = pick_idx;
               gnt_valid_d = 1'b1;
               rr_ptr_d    = pick_idx + 3'd1;
               hold_cnt_d  = '0;
            end
         end
         StBusy: begin
            if (end_grant) begin
               hold_cnt_d = '0;
               timeout_d  = end_hold & ~end_release & ~end_drop;
               if (en && pick_found) begin
                  // Hand over on the same edge: no idle bubble.
                  gnt_d       = 8'd1 << pick_idx;
                  gnt_idx_d   = pick_idx;
                  gnt_valid_d = 1'b1;
                  rr_ptr_d    = pick_idx + 3'd1;
               end else begin
                  state_d     = StIdle;
                  gnt_d       = 8'd0;
                  gnt_idx_d   = 3'd0;
                  gnt_valid_d = 1'b0;
               end
            end else if (hold_cnt_q != '1) begin
               // Saturate so a disabled timeout never wraps the counter.
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = StIdle;
            gnt_d       = 8'd0;
            gnt_idx_d   = 3'd0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops any grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         gnt_q       <= 8'd0;
         gnt_idx_q   <= 3'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         rr_ptr_q    <= 3'd0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         rr_ptr_q    <= rr_ptr_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: reset, fixed priority, round-robin,
// hold timeout, owner drop, enable gating and pointer wrap.
module tb_rr_grant_arbiter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       rr_mode;
   logic [7:0] req;
   logic       release_i;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rr_grant_arbiter #(
      .MAX_HOLD (16),
      .HOLD_W   (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rr_mode   (rr_mode),
      .req       (req),
      .release_i (release_i),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full output check against an expected grant index / idle state.
   task automatic check_out(input string tag, input logic valid, input logic [2:0] idx,
                            input logic to);
      logic [7:0] exp_gnt;
      exp_gnt = valid ? (8'd1 << idx) : 8'd0;
      check({tag, " gnt"}, gnt, exp_gnt);
      check({tag, " idx"}, {5'd0, gnt_idx}, valid ? {5'd0, idx} : 8'd0);
      check({tag, " valid"}, {7'd0, gnt_valid}, {7'd0, valid});
      check({tag, " timeout"}, {7'd0, timeout}, {7'd0, to});
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      rr_mode   = 1'b0;
      req       = 8'h00;
      release_i = 1'b0;
      tick();
      tick();
      check_out("reset", 1'b0, 3'd0, 1'b0);
      rst_n = 1'b1;
      tick();

      // Fixed priority: lowest set bit wins, handover on release without a bubble.
      en  = 1'b1;
      req = 8'h28;
      tick();
      check_out("fp first", 1'b1, 3'd3, 1'b0);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check_out("fp handover", 1'b1, 3'd5, 1'b0);
      // Owner drops its request: grant ends on the next edge.
      req = 8'h00;
      tick();
      check_out("owner drop", 1'b0, 3'd0, 1'b0);

      // en=0 blocks new grants; raising en grants one cycle later.
      en  = 1'b0;
      req = 8'h0F;
      tick();
      tick();
      check_out("en low", 1'b0, 3'd0, 1'b0);
      en = 1'b1;
      tick();
      check_out("en raise", 1'b1, 3'd0, 1'b0);
      req = 8'h00;
      tick();
      check_out("en drop", 1'b0, 3'd0, 1'b0);

      // Reset mid-grant: outputs clear asynchronously and rr_ptr returns to 0.
      req = 8'h04;
      tick();
      check_out("pre reset", 1'b1, 3'd2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async reset", 1'b0, 3'd0, 1'b0);
      tick();
      rst_n   = 1'b1;
      rr_mode = 1'b1;
      req     = 8'h11; // pointer at 0 picks idx 0; a stale pointer of 3 would pick 4
      tick();
      check_out("post reset", 1'b1, 3'd0, 1'b0);

      // Round-robin lap with all requesting, release every second cycle.
      req = 8'hFF;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_out("rr hold", 1'b1, 3'(i - 1), 1'b0);
         release_i = 1'b1;
         tick();
         release_i = 1'b0;
         check_out("rr next", 1'b1, 3'(i), 1'b0);
      end
      req = 8'h00;
      tick();
      check_out("rr idle", 1'b0, 3'd0, 1'b0);

      // Timeout: sole requester 7 is force-released after 16 grant cycles.
      req = 8'h80;
      tick();
      check_out("to grant", 1'b1, 3'd7, 1'b0);
      for (int i = 1; i < 16; i++) begin
         tick();
      end
      check_out("to held", 1'b1, 3'd7, 1'b0);
      tick();
      check_out("to pulse", 1'b0, 3'd0, 1'b1);
      tick();
      check_out("to regrant", 1'b1, 3'd7, 1'b0);
      req = 8'h81;
      for (int i = 1; i < 16; i++) begin
         tick();
      end
      check_out("to held2", 1'b1, 3'd7, 1'b0);
      tick();
      check_out("to b2b", 1'b1, 3'd0, 1'b1);
      req = 8'h00;
      tick();
      check_out("to drop", 1'b0, 3'd0, 1'b0);

      // Wrap: put rr_ptr at 7, then idx 0 wins before idx 6.
      req = 8'h40;
      tick();
      check_out("wrap setup", 1'b1, 3'd6, 1'b0);
      req = 8'h00;
      tick();
      check_out("wrap idle", 1'b0, 3'd0, 1'b0);
      req = 8'h41;
      tick();
      check_out("wrap first", 1'b1, 3'd0, 1'b0);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check_out("wrap second", 1'b1, 3'd6, 1'b0);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check_out("wrap third", 1'b1, 3'd0, 1'b0);
      req = 8'h00;
      tick();
      check_out("wrap idle2", 1'b0, 3'd0, 1'b0);

      // en=0 while busy: grant kept until end-of-grant, then idle.
      req = 8'h02;
      tick();
      check_out("enb grant", 1'b1, 3'd1, 1'b0);
      en  = 1'b0;
      req = 8'h03;
      tick();
      check_out("enb kept", 1'b1, 3'd1, 1'b0);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check_out("enb end", 1'b0, 3'd0, 1'b0);

      // Release in idle is ignored.
      en  = 1'b1;
      req = 8'h00;
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check_out("idle release", 1'b0, 3'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
